// File: rtl/mem_pkg.sv
// Shared types and constants for the MEM stage: access FSM encoding,
// word-alignment mask and the MEM/WB control bubble.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } memState_e;

    localparam logic [31:0] WordMask = 32'h0000_0003;

    typedef struct packed {
        logic regWrite;
        logic memToReg;
    } wbCtrl_t;

    localparam wbCtrl_t WbBubble = '{regWrite: 1'b0, memToReg: 1'b0};

    function automatic logic isMisaligned(input logic [31:0] addr);
        return (addr & WordMask) != 32'h0;
    endfunction

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory access sequencer: issues one req/ack transaction per aligned
// load/store, stalls the pipeline meanwhile and aborts after TIMEOUT cycles.
module dmem_access_fsm #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        dmemAck,
    input  logic [31:0] dmemRdata,
    output logic        stall,
    output logic        done,
    output logic        aborted,
    output logic        fault,
    output logic        misaligned,
    output logic [31:0] rdata,
    output logic        dmemReq,
    output logic        dmemWe,
    output logic [31:0] dmemAddr,
    output logic [31:0] dmemWdata
);
    import mem_pkg::*;

    memState_e   state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        we_q, aborted_q, fault_q;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic        op, start, timeoutHit;

    assign op         = memRead | memWrite;
    assign misaligned = op & isMisaligned(addr);
    assign start      = (state_q == StIdle) & op & ~misaligned;
    assign timeoutHit = (state_q == StBusy) & ~dmemAck & (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StBusy;
                    cnt_d   = 8'd0;
                end
            end
            StBusy: begin
                if (dmemAck || timeoutHit) state_d = StDone;
                else                       cnt_d   = cnt_q + 8'd1;
            end
            // Leaving DONE unconditionally keeps the held EX/MEM entry from re-issuing.
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= 8'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
            aborted_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fault_q <= ((state_q == StIdle) & misaligned) | timeoutHit;
            if (start) begin
                we_q      <= memWrite;
                addr_q    <= addr & ~WordMask;
                wdata_q   <= wdata;
                rdata_q   <= 32'h0;
                aborted_q <= 1'b0;
            end
            if ((state_q == StBusy) && dmemAck && !we_q) rdata_q <= dmemRdata;
            if (timeoutHit) aborted_q <= 1'b1;
        end
    end

    assign stall     = start | (state_q == StBusy);
    assign done      = (state_q == StDone);
    assign aborted   = aborted_q;
    assign fault     = fault_q;
    assign rdata     = rdata_q;
    assign dmemReq   = (state_q == StBusy);
    assign dmemWe    = we_q;
    assign dmemAddr  = addr_q;
    assign dmemWdata = wdata_q;

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the MIPS datapath: branch resolution, data-memory access via
// dmem_access_fsm and the MEM/WB pipeline register.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite_M,
    input  logic        MemToReg_M,
    input  logic        MemWrite_M,
    input  logic        MemRead_M,
    input  logic        Branch_M,
    input  logic [31:0] BranchResult_M,
    input  logic        ZeroF_M,
    input  logic [31:0] ALURes_M,
    input  logic [31:0] Dato2_M,
    input  logic [4:0]  WREG_M,
    output logic        PCSrc,
    output logic [31:0] BranchTarget,
    output logic        stall,
    output logic        mem_fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        RegWrite_W,
    output logic        MemToReg_W,
    output logic [31:0] ReadData_W,
    output logic [31:0] ALURes_W,
    output logic [4:0]  WREG_W
);
    import mem_pkg::*;

    logic        done, aborted, misaligned;
    logic [31:0] rdata;
    wbCtrl_t     ctrl_q;

    dmem_access_fsm #(
        .TIMEOUT(TIMEOUT)
    ) u_access (
        .clk       (clk),
        .rst       (rst),
        .memRead   (MemRead_M),
        .memWrite  (MemWrite_M),
        .addr      (ALURes_M),
        .wdata     (Dato2_M),
        .dmemAck   (dmem_ack),
        .dmemRdata (dmem_rdata),
        .stall     (stall),
        .done      (done),
        .aborted   (aborted),
        .fault     (mem_fault),
        .misaligned(misaligned),
        .rdata     (rdata),
        .dmemReq   (dmem_req),
        .dmemWe    (dmem_we),
        .dmemAddr  (dmem_addr),
        .dmemWdata (dmem_wdata)
    );

    assign PCSrc        = ~rst & Branch_M & ZeroF_M;
    assign BranchTarget = BranchResult_M;

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= WbBubble;
            ReadData_W <= 32'h0;
            ALURes_W   <= 32'h0;
            WREG_W     <= 5'd0;
        end else if (stall) begin
            ctrl_q <= WbBubble;
        end else begin
            // Faulted accesses retire without a register write.
            ctrl_q.regWrite <= RegWrite_M & ~misaligned & ~(done & aborted);
            ctrl_q.memToReg <= MemToReg_M;
            ReadData_W      <= done ? rdata : 32'h0;
            ALURes_W        <= ALURes_M;
            WREG_W          <= WREG_M;
        end
    end

    assign RegWrite_W = ctrl_q.regWrite;
    assign MemToReg_W = ctrl_q.memToReg;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized
// instruction streams checked against a word-array memory model.
module tb_mem_stage;
    localparam int unsigned TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite_M, MemToReg_M, MemWrite_M, MemRead_M, Branch_M, ZeroF_M;
    logic [31:0] BranchResult_M, ALURes_M, Dato2_M;
    logic [4:0]  WREG_M;
    logic        PCSrc, stall, mem_fault, dmem_req, dmem_we, dmem_ack;
    logic [31:0] BranchTarget, dmem_addr, dmem_wdata, dmem_rdata;
    logic        RegWrite_W, MemToReg_W;
    logic [31:0] ReadData_W, ALURes_W;
    logic [4:0]  WREG_W;

    int tests = 0;
    int fails = 0;

    logic [31:0] respMem  [64];
    logic [31:0] modelMem [64];

    // Observations from the last run_instr call.
    int          sCyc, rCyc, rRise, fCyc, bRegW;
    logic        aStable, fWe, hung;
    logic [31:0] fAddr, fWdata;

    mem_stage #(.TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .RegWrite_M    (RegWrite_M),
        .MemToReg_M    (MemToReg_M),
        .MemWrite_M    (MemWrite_M),
        .MemRead_M     (MemRead_M),
        .Branch_M      (Branch_M),
        .BranchResult_M(BranchResult_M),
        .ZeroF_M       (ZeroF_M),
        .ALURes_M      (ALURes_M),
        .Dato2_M       (Dato2_M),
        .WREG_M        (WREG_M),
        .PCSrc         (PCSrc),
        .BranchTarget  (BranchTarget),
        .stall         (stall),
        .mem_fault     (mem_fault),
        .dmem_req      (dmem_req),
        .dmem_we       (dmem_we),
        .dmem_addr     (dmem_addr),
        .dmem_wdata    (dmem_wdata),
        .dmem_rdata    (dmem_rdata),
        .dmem_ack      (dmem_ack),
        .RegWrite_W    (RegWrite_W),
        .MemToReg_W    (MemToReg_W),
        .ReadData_W    (ReadData_W),
        .ALURes_W      (ALURes_W),
        .WREG_W        (WREG_W)
    );

    always #5 clk = ~clk;

    task automatic set_nop();
        RegWrite_M = 0; MemToReg_M = 0; MemWrite_M = 0; MemRead_M = 0;
        Branch_M = 0; ZeroF_M = 0; BranchResult_M = 0; ALURes_M = 0; Dato2_M = 0; WREG_M = 0;
    endtask

    // Presents one EX/MEM entry, acts as the memory responder (ack in the
    // ackLat-th cycle of dmem_req, 0 = never) and returns after the MEM/WB capture.
    task automatic run_instr(input logic rw, input logic m2r, input logic mw, input logic mr,
                             input logic [31:0] alu, input logic [31:0] d2,
                             input logic [4:0] wreg, input int ackLat);
        logic prevReq;
        @(posedge clk); #1;
        RegWrite_M = rw; MemToReg_M = m2r; MemWrite_M = mw; MemRead_M = mr;
        ALURes_M = alu; Dato2_M = d2; WREG_M = wreg; Branch_M = 0;
        sCyc = 0; rCyc = 0; rRise = 0; fCyc = 0; bRegW = 0;
        aStable = 1; fWe = 0; fAddr = 0; fWdata = 0; hung = 1; prevReq = 0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            dmem_ack = 0;
            dmem_rdata = $urandom;
            if (mem_fault) fCyc++;
            if (dmem_req) begin
                rCyc++;
                if (!prevReq) begin
                    rRise++; fAddr = dmem_addr; fWe = dmem_we; fWdata = dmem_wdata;
                end else if (dmem_addr !== fAddr || dmem_we !== fWe || dmem_wdata !== fWdata) begin
                    aStable = 0;
                end
                if (rCyc == ackLat) begin
                    dmem_ack = 1;
                    if (dmem_we) respMem[dmem_addr[7:2]] = dmem_wdata;
                    else         dmem_rdata = respMem[dmem_addr[7:2]];
                end
            end
            prevReq = dmem_req;
            if (stall) begin
                sCyc++;
                if (sCyc > 1 && RegWrite_W) bRegW++;
            end else begin
                @(posedge clk); #1;
                dmem_ack = 0;
                set_nop();
                if (mem_fault) fCyc++;
                hung = 0;
                break;
            end
        end
        dmem_ack = 0;
        if (hung) set_nop();
    endtask

    task automatic test_reset();
        set_nop();
        dmem_ack = 0; dmem_rdata = 0;
        rst = 1;
        Branch_M = 1; ZeroF_M = 1; BranchResult_M = 32'h40;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (PCSrc !== 1'b0) begin fails++;
            $display("FAIL reset_pcsrc got=%0b exp=0", PCSrc); end
        tests++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin fails++;
            $display("FAIL reset_req_we got=%0b%0b exp=00", dmem_req, dmem_we); end
        tests++; if (dmem_addr !== 32'h0 || dmem_wdata !== 32'h0) begin fails++;
            $display("FAIL reset_addr_wdata got=%h/%h exp=0/0", dmem_addr, dmem_wdata); end
        tests++; if ({RegWrite_W, MemToReg_W, WREG_W, mem_fault} !== 8'h0) begin fails++;
            $display("FAIL reset_wb_ctrl got=%b exp=0", {RegWrite_W, MemToReg_W, WREG_W, mem_fault});
        end
        tests++; if (ReadData_W !== 32'h0 || ALURes_W !== 32'h0) begin fails++;
            $display("FAIL reset_wb_data got=%h/%h exp=0/0", ReadData_W, ALURes_W); end
        set_nop();
        rst = 0;
    endtask

    task automatic test_alu();
        run_instr(1, 0, 0, 0, 32'h0000_00A5, 32'h55, 5'd7, 0);
        tests++; if (hung !== 1'b0 || sCyc != 0) begin fails++;
            $display("FAIL alu_stall got=%0d hung=%0b exp=0", sCyc, hung); end
        tests++; if ({RegWrite_W, MemToReg_W, WREG_W} !== {1'b1, 1'b0, 5'd7}) begin fails++;
            $display("FAIL alu_ctrl got=%0b%0b/%0d exp=10/7", RegWrite_W, MemToReg_W, WREG_W); end
        tests++; if (ALURes_W !== 32'hA5 || ReadData_W !== 32'h0) begin fails++;
            $display("FAIL alu_data got=%h/%h exp=a5/0", ALURes_W, ReadData_W); end
        tests++; if (rRise != 0 || fCyc != 0) begin fails++;
            $display("FAIL alu_noreq got req=%0d fault=%0d exp=0/0", rRise, fCyc); end
    endtask

    task automatic test_load();
        respMem[0] = 32'hDEAD_BEEF;
        run_instr(1, 1, 0, 1, 32'h100, 32'h0, 5'd5, 3);
        tests++; if (hung !== 1'b0 || sCyc != 4) begin fails++;
            $display("FAIL load_stall got=%0d exp=4", sCyc); end
        tests++; if (rRise != 1 || rCyc != 3 || fWe !== 1'b0 || fAddr !== 32'h100) begin fails++;
            $display("FAIL load_req got rise=%0d cyc=%0d we=%0b addr=%h exp=1/3/0/100",
                     rRise, rCyc, fWe, fAddr); end
        tests++; if (aStable !== 1'b1 || bRegW != 0) begin fails++;
            $display("FAIL load_stable got stable=%0b bubbleRegW=%0d exp=1/0", aStable, bRegW); end
        tests++; if (ReadData_W !== 32'hDEAD_BEEF || MemToReg_W !== 1'b1 || RegWrite_W !== 1'b1)
            begin fails++;
            $display("FAIL load_wb got=%h m2r=%0b rw=%0b exp=deadbeef/1/1",
                     ReadData_W, MemToReg_W, RegWrite_W); end
    endtask

    task automatic test_store();
        run_instr(0, 0, 1, 0, 32'h200, 32'h1234_5678, 5'd3, 1);
        tests++; if (hung !== 1'b0 || sCyc != 2) begin fails++;
            $display("FAIL store_stall got=%0d exp=2", sCyc); end
        tests++; if (fWe !== 1'b1 || fWdata !== 32'h1234_5678 || fAddr !== 32'h200) begin fails++;
            $display("FAIL store_req got we=%0b wdata=%h addr=%h exp=1/12345678/200",
                     fWe, fWdata, fAddr); end
        tests++; if (RegWrite_W !== 1'b0 || ReadData_W !== 32'h0) begin fails++;
            $display("FAIL store_wb got rw=%0b rd=%h exp=0/0", RegWrite_W, ReadData_W); end
        tests++; if (respMem[0] !== 32'h1234_5678) begin fails++;
            $display("FAIL store_mem got=%h exp=12345678", respMem[0]); end
    endtask

    task automatic test_misaligned();
        run_instr(1, 1, 0, 1, 32'h103, 32'h0, 5'd9, 2);
        tests++; if (hung !== 1'b0 || sCyc != 0 || rRise != 0) begin fails++;
            $display("FAIL misal_noreq got stall=%0d req=%0d exp=0/0", sCyc, rRise); end
        tests++; if (fCyc != 1 || mem_fault !== 1'b1) begin fails++;
            $display("FAIL misal_fault got cycles=%0d now=%0b exp=1/1", fCyc, mem_fault); end
        tests++; if (RegWrite_W !== 1'b0 || ALURes_W !== 32'h103 || WREG_W !== 5'd9) begin fails++;
            $display("FAIL misal_wb got rw=%0b alu=%h wreg=%0d exp=0/103/9",
                     RegWrite_W, ALURes_W, WREG_W); end
        @(posedge clk); #1;
        tests++; if (mem_fault !== 1'b0) begin fails++;
            $display("FAIL misal_pulse got=%0b exp=0", mem_fault); end
    endtask

    task automatic test_timeout();
        run_instr(1, 1, 0, 1, 32'h104, 32'h0, 5'd4, 0);
        tests++; if (hung !== 1'b0 || rCyc != int'(TIMEOUT) || rRise != 1) begin fails++;
            $display("FAIL timeout_req got cycles=%0d rises=%0d exp=%0d/1", rCyc, rRise, TIMEOUT);
        end
        tests++; if (sCyc != int'(TIMEOUT) + 1 || fCyc != 1) begin fails++;
            $display("FAIL timeout_stall got stall=%0d fault=%0d exp=%0d/1",
                     sCyc, fCyc, TIMEOUT + 1); end
        tests++; if (RegWrite_W !== 1'b0 || ReadData_W !== 32'h0 || dmem_req !== 1'b0) begin
            fails++;
            $display("FAIL timeout_wb got rw=%0b rd=%h req=%0b exp=0/0/0",
                     RegWrite_W, ReadData_W, dmem_req); end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(posedge clk); #1;
        RegWrite_M = 1; MemToReg_M = 1; MemRead_M = 1; ALURes_M = 32'h108; WREG_M = 5'd12;
        seen = 0;
        for (int c = 0; c < 8 && seen == 0; c++) begin
            @(negedge clk);
            if (dmem_req) seen = 1;
        end
        tests++; if (seen != 1) begin fails++;
            $display("FAIL rstmid_req got=%0d exp=1", seen); end
        @(posedge clk); #1;
        rst = 1; set_nop();
        @(posedge clk); #1;
        rst = 0;
        tests++; if (dmem_req !== 1'b0 || stall !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 0)
            begin fails++;
            $display("FAIL rstmid_idle got req=%0b stall=%0b we=%0b addr=%h exp=0/0/0/0",
                     dmem_req, stall, dmem_we, dmem_addr); end
        @(negedge clk);
        @(negedge clk);
        dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_ack = 0;
        tests++; if (dmem_req !== 1'b0 || stall !== 1'b0 || mem_fault !== 1'b0) begin fails++;
            $display("FAIL rstmid_stale got req=%0b stall=%0b fault=%0b exp=0/0/0",
                     dmem_req, stall, mem_fault); end
        tests++; if (ReadData_W !== 32'h0 || RegWrite_W !== 1'b0) begin fails++;
            $display("FAIL rstmid_wb got rd=%h rw=%0b exp=0/0", ReadData_W, RegWrite_W); end
        run_instr(1, 0, 0, 0, 32'h77, 32'h0, 5'd2, 0);
        tests++; if (hung !== 1'b0 || sCyc != 0 || RegWrite_W !== 1'b1 || ALURes_W !== 32'h77)
            begin fails++;
            $display("FAIL rstmid_next got stall=%0d rw=%0b alu=%h exp=0/1/77",
                     sCyc, RegWrite_W, ALURes_W); end
    endtask

    task automatic test_branch();
        logic b, z, exp;
        logic [31:0] t;
        @(posedge clk); #1;
        Branch_M = 1; ZeroF_M = 1; BranchResult_M = 32'h40;
        #1;
        tests++; if (PCSrc !== 1'b1 || BranchTarget !== 32'h40) begin fails++;
            $display("FAIL branch_taken got=%0b/%h exp=1/40", PCSrc, BranchTarget); end
        for (int i = 0; i < 8; i++) begin
            b = 1'($urandom); z = 1'($urandom); t = $urandom;
            Branch_M = b; ZeroF_M = z; BranchResult_M = t;
            exp = b && z;
            #1;
            tests++; if (PCSrc !== exp || BranchTarget !== t) begin fails++;
                $display("FAIL branch_rand got=%0b/%h exp=%0b/%h", PCSrc, BranchTarget, exp, t); end
        end
        set_nop();
    endtask

    task automatic test_random();
        for (int i = 0; i < 64; i++) begin
            respMem[i] = $urandom;
            modelMem[i] = respMem[i];
        end
        for (int n = 0; n < 40; n++) begin
            int kind, lat, expStall, expFault;
            logic rw, m2r, mw, mr, op, mis, expRW;
            logic [31:0] alu, d2, expRD;
            logic [4:0] wreg;
            kind = $urandom_range(0, 3);
            lat = $urandom_range(1, 5);
            rw = 1'($urandom); m2r = 1'($urandom); wreg = 5'($urandom); d2 = $urandom;
            alu = {24'h0, 6'($urandom), 2'b00};
            mr = 0; mw = 0;
            case (kind)
                0: alu = $urandom;
                1: begin mr = 1; mw = ($urandom_range(0, 3) == 0); end
                2: mw = 1;
                default: begin
                    mr = 1'($urandom); mw = ~mr; alu[1:0] = 2'($urandom_range(1, 3));
                end
            endcase
            op = mr | mw;
            mis = op && (alu % 4 != 0);
            expStall = (op && !mis) ? lat + 1 : 0;
            expFault = mis ? 1 : 0;
            expRW = rw && !mis;
            expRD = (op && !mis && !mw) ? modelMem[alu[7:2]] : 32'h0;
            if (op && !mis && mw) modelMem[alu[7:2]] = d2;
            run_instr(rw, m2r, mw, mr, alu, d2, wreg, lat);
            tests++; if (hung !== 1'b0 || sCyc != expStall || fCyc != expFault) begin fails++;
                $display("FAIL rand_timing n=%0d got stall=%0d fault=%0d exp=%0d/%0d",
                         n, sCyc, fCyc, expStall, expFault); end
            tests++; if ({RegWrite_W, MemToReg_W, WREG_W} !== {expRW, m2r, wreg}) begin fails++;
                $display("FAIL rand_ctrl n=%0d got=%0b%0b/%0d exp=%0b%0b/%0d",
                         n, RegWrite_W, MemToReg_W, WREG_W, expRW, m2r, wreg); end
            tests++; if (ReadData_W !== expRD || ALURes_W !== alu) begin fails++;
                $display("FAIL rand_data n=%0d got=%h/%h exp=%h/%h",
                         n, ReadData_W, ALURes_W, expRD, alu); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_branch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
